// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Shares the lab ALU and its 8-bit result register between two requesters.
//   A round-robin arbiter accepts one command at a time. ALU commands
//   (op 000-110) are issued for one cycle, and the ALU output is captured into
//   the accumulator. Op 111 runs a 4x4 shift-add multiply internally over
//   four cycles. The result goes back to the owner with a one-cycle done pulse.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   req0/1, op0/1          command request and code per requester
//   a0, b0, a1, b1         4-bit operands, latched at the accepting edge
//   gnt0/1, done0/1        registered one-cycle accept / result-valid pulses
//   result                 accumulator value as of the last completed command
//   busy                   high whenever the controller is not idle
//   alu_select/a/b         ALU drive lines; zero outside ISSUE
//   alu_reg                ALU register input, mirrors the accumulator
//   alu_out                combinational ALU result

module alu_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result,
    output logic       busy,
    output logic [2:0] alu_select,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [7:0] alu_reg,
    input  logic [7:0] alu_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, MUL, RESP} state_t;

    state_t     state, state_nx;
    logic       owner, owner_nx;
    logic       last, last_nx;
    logic [2:0] opl, opl_nx;
    logic [3:0] al, al_nx;
    logic [3:0] bl, bl_nx;
    logic [7:0] acc, acc_nx;
    logic [1:0] cnt, cnt_nx;
    logic [7:0] result_nx;
    logic       gnt0_nx, gnt1_nx, done0_nx, done1_nx, busy_nx;

    logic       win;
    logic [2:0] win_op;
    logic [3:0] win_a, win_b;

    // Arbitration: a lone requester wins; on contention the side that was
    // not served last wins.
    always_comb begin
        win    = (req0 && req1) ? ~last : req1;
        win_op = win ? op1 : op0;
        win_a  = win ? a1  : a0;
        win_b  = win ? b1  : b0;
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        last_nx   = last;
        opl_nx    = opl;
        al_nx     = al;
        bl_nx     = bl;
        acc_nx    = acc;
        cnt_nx    = cnt;
        result_nx = result;
        gnt0_nx   = 1'b0;
        gnt1_nx   = 1'b0;
        done0_nx  = 1'b0;
        done1_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nx = win;
                    last_nx  = win;
                    opl_nx   = win_op;
                    al_nx    = win_a;
                    bl_nx    = win_b;
                    gnt0_nx  = ~win;
                    gnt1_nx  = win;
                    if (win_op == 3'b111) begin
                        acc_nx   = '0;
                        cnt_nx   = '0;
                        state_nx = MUL;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                acc_nx    = alu_out;
                result_nx = alu_out;
                done0_nx  = ~owner;
                done1_nx  = owner;
                state_nx  = RESP;
            end
            MUL: begin
                if (bl[cnt]) begin
                    acc_nx = acc + ({4'b0000, al} << cnt);
                end
                cnt_nx = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    // result is registered, so load it with the final partial
                    // sum now so it is valid alongside the done pulse
                    result_nx = acc_nx;
                    done0_nx  = ~owner;
                    done1_nx  = owner;
                    state_nx  = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            opl    <= '0;
            al     <= '0;
            bl     <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            last   <= last_nx;
            opl    <= opl_nx;
            al     <= al_nx;
            bl     <= bl_nx;
            acc    <= acc_nx;
            cnt    <= cnt_nx;
            result <= result_nx;
            gnt0   <= gnt0_nx;
            gnt1   <= gnt1_nx;
            done0  <= done0_nx;
            done1  <= done1_nx;
            busy   <= busy_nx;
        end
    end

    always_comb begin
        alu_select = (state == ISSUE) ? opl : '0;
        alu_a      = (state == ISSUE) ? al  : '0;
        alu_b      = (state == ISSUE) ? bl  : '0;
        alu_reg    = acc;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. Provides a lab ALU model on the
//   ALU lines and compares DUT behaviour against an arithmetic reference.
//   Ports: none (top-level bench).

module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] result;
    logic [2:0] alu_select;
    logic [3:0] alu_a, alu_b;
    logic [7:0] alu_reg, alu_out;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_acc;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .result     (result),
        .busy       (busy),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_reg    (alu_reg),
        .alu_out    (alu_out)
    );

    // Lab ALU: 000 add, 001 or, 010 and, 011 xor, 100 sub,
    // 101 {a, b[1:0], 00}, 110 pass register.
    always_comb begin
        case (alu_select)
            3'd0:    alu_out = {4'b0, alu_a} + {4'b0, alu_b};
            3'd1:    alu_out = {4'b0, alu_a | alu_b};
            3'd2:    alu_out = {4'b0, alu_a & alu_b};
            3'd3:    alu_out = {4'b0, alu_a ^ alu_b};
            3'd4:    alu_out = {4'b0, alu_a} - {4'b0, alu_b};
            3'd5:    alu_out = {alu_a, alu_b[1:0], 2'b00};
            3'd6:    alu_out = alu_reg;
            default: alu_out = 8'h00;
        endcase
    end

    // Reference result of a command, computed with plain integer arithmetic.
    function automatic logic [7:0] ref_result(input int op, input int a, input int b,
                                              input logic [7:0] acc);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a | b;
            2:       r = a & b;
            3:       r = a ^ b;
            4:       r = a - b;
            5:       r = a * 16 + (b % 4) * 4;
            6:       r = int'(acc);
            default: r = a * b;
        endcase
        return 8'(r);
    endfunction

    // Drive one command from one side and record what happened, cycle 1 being
    // the cycle after the accepting edge. Operands are scrambled after gnt to
    // show they were latched. Returns one cycle after done (back in IDLE).
    task automatic run_cmd(input bit side, input logic [2:0] op,
                           input logic [3:0] a, input logic [3:0] b,
                           output int gnt_cyc, output int done_cyc,
                           output logic [7:0] res, output logic [10:0] drv,
                           output int busy_cyc, output int stray);
        gnt_cyc  = -1;
        done_cyc = -1;
        res      = '0;
        drv      = '0;
        busy_cyc = 0;
        stray    = 0;
        if (side) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        for (int cyc = 1; cyc <= 12 && done_cyc < 0; cyc++) begin
            @(posedge clock);
            #1;
            if (busy) busy_cyc++;
            if (side ? (gnt0 || done0) : (gnt1 || done1)) stray++;
            if ((side ? gnt1 : gnt0) && gnt_cyc < 0) begin
                gnt_cyc = cyc;
                drv     = {alu_select, alu_a, alu_b};
                if (side) begin
                    req1 = 1'b0; a1 = ~a; b1 = ~b;
                end else begin
                    req0 = 1'b0; a0 = ~a; b0 = ~b;
                end
            end
            if (side ? done1 : done0) begin
                done_cyc = cyc;
                res      = result;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {gnt0, gnt1, done0, done1, busy});
        end
        total++;
        if (result !== 8'h00) begin
            bad++;
            $display("FAIL reset_result: got %h want 00", result);
        end
        total++;
        if ({alu_select, alu_a, alu_b} !== 11'b0) begin
            bad++;
            $display("FAIL reset_alu_drive: got %h want 000", {alu_select, alu_a, alu_b});
        end
        total++;
        if (alu_reg !== 8'h00) begin
            bad++;
            $display("FAIL reset_acc: got %h want 00", alu_reg);
        end
        reset = 1'b0;
        model_acc = 8'h00;
    endtask

    task automatic test_alu_ops;
        int g, d, bc, st;
        logic [7:0] r;
        logic [10:0] dv;

        run_cmd(1'b0, 3'd1, 4'd3, 4'd4, g, d, r, dv, bc, st);
        total++;
        if (g !== 1 || d !== 2) begin
            bad++;
            $display("FAIL or_timing: got gnt=%0d done=%0d want gnt=1 done=2", g, d);
        end
        total++;
        if (r !== 8'h07) begin
            bad++;
            $display("FAIL or_result: got %h want 07", r);
        end
        total++;
        if (bc !== 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL or_busy: got busy_cycles=%0d busy_after=%b want 2 and 0", bc, busy);
        end
        total++;
        if (dv !== {3'd1, 4'd3, 4'd4} || st !== 0) begin
            bad++;
            $display("FAIL or_drive: got drive=%h stray=%0d want %h and 0", dv, st, {3'd1, 4'd3, 4'd4});
        end

        run_cmd(1'b1, 3'd0, 4'h9, 4'h9, g, d, r, dv, bc, st);
        total++;
        if (r !== 8'h12 || d !== 2 || st !== 0) begin
            bad++;
            $display("FAIL add_side1: got result=%h done=%0d stray=%0d want 12 2 0", r, d, st);
        end

        run_cmd(1'b1, 3'd5, 4'hA, 4'h3, g, d, r, dv, bc, st);
        total++;
        if (r !== 8'hAC || d !== 2) begin
            bad++;
            $display("FAIL op5_result: got result=%h done=%0d want AC 2", r, d);
        end

        run_cmd(1'b1, 3'd6, 4'h1, 4'h2, g, d, r, dv, bc, st);
        total++;
        if (r !== 8'hAC || alu_reg !== 8'hAC) begin
            bad++;
            $display("FAIL reread: got result=%h acc=%h want AC AC", r, alu_reg);
        end
        model_acc = 8'hAC;
    endtask

    task automatic test_multiply;
        int g, d, bc, st;
        logic [7:0] r;
        logic [10:0] dv;

        run_cmd(1'b0, 3'd7, 4'hF, 4'hF, g, d, r, dv, bc, st);
        total++;
        if (g !== 1 || d !== 5) begin
            bad++;
            $display("FAIL mul_timing: got gnt=%0d done=%0d want gnt=1 done=5", g, d);
        end
        total++;
        if (r !== 8'hE1 || alu_reg !== 8'hE1) begin
            bad++;
            $display("FAIL mul_ff: got result=%h acc=%h want E1 E1", r, alu_reg);
        end
        total++;
        if (dv !== 11'b0 || bc !== 5) begin
            bad++;
            $display("FAIL mul_drive_busy: got drive=%h busy_cycles=%0d want 000 5", dv, bc);
        end

        run_cmd(1'b0, 3'd7, 4'h5, 4'h0, g, d, r, dv, bc, st);
        total++;
        if (r !== 8'h00 || d !== 5) begin
            bad++;
            $display("FAIL mul_zero: got result=%h done=%0d want 00 5", r, d);
        end
        model_acc = 8'h00;
    endtask

    task automatic test_random;
        int g, d, bc, st;
        logic [7:0] r, exp;
        logic [10:0] dv, exp_dv;
        bit side;
        logic [2:0] op;
        logic [3:0] a, b;

        for (int i = 0; i < 16; i++) begin
            side = 1'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            a    = 4'($urandom_range(0, 15));
            b    = 4'($urandom_range(0, 15));
            exp    = ref_result(int'(op), int'(a), int'(b), model_acc);
            exp_dv = (op == 3'd7) ? 11'b0 : {op, a, b};
            run_cmd(side, op, a, b, g, d, r, dv, bc, st);
            total++;
            if (r !== exp) begin
                bad++;
                $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h want %h", i, op, a, b, r, exp);
            end
            total++;
            if (g !== 1 || d !== ((op == 3'd7) ? 5 : 2) || st !== 0) begin
                bad++;
                $display("FAIL rand_timing[%0d]: op=%0d got gnt=%0d done=%0d stray=%0d want 1 %0d 0",
                         i, op, g, d, st, (op == 3'd7) ? 5 : 2);
            end
            total++;
            if (dv !== exp_dv) begin
                bad++;
                $display("FAIL rand_drive[%0d]: got %h want %h", i, dv, exp_dv);
            end
            model_acc = exp;
        end
    endtask

    task automatic test_back_to_back;
        int gside[$];
        int dside[$];
        int dcyc[$];
        logic [7:0] dres[$];
        int overlap;
        logic [7:0] want;

        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        overlap = 0;
        req0 = 1'b1; op0 = 3'd0; a0 = 4'd1; b0 = 4'd2;
        req1 = 1'b1; op1 = 3'd3; a1 = 4'd5; b1 = 4'd3;
        for (int cyc = 1; cyc <= 30 && dside.size() < 4; cyc++) begin
            @(posedge clock);
            #1;
            if (gnt0) gside.push_back(0);
            if (gnt1) gside.push_back(1);
            if (done0) begin dside.push_back(0); dcyc.push_back(cyc); dres.push_back(result); end
            if (done1) begin dside.push_back(1); dcyc.push_back(cyc); dres.push_back(result); end
            if ((gnt0 || gnt1) && (done0 || done1)) overlap++;
            if ((gnt0 && gnt1) || (done0 && done1)) overlap++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clock);
        #1;

        total++;
        if (gside.size() !== 4 || dside.size() !== 4) begin
            bad++;
            $display("FAIL b2b_count: got gnts=%0d dones=%0d want 4 4", gside.size(), dside.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                want = (i % 2 == 1) ? 8'h06 : 8'h03;
                total++;
                if (gside[i] !== i % 2 || dside[i] !== i % 2) begin
                    bad++;
                    $display("FAIL b2b_order[%0d]: got gnt_side=%0d done_side=%0d want %0d", i, gside[i], dside[i], i % 2);
                end
                total++;
                if (dcyc[i] !== 2 + 3 * i || dres[i] !== want) begin
                    bad++;
                    $display("FAIL b2b_done[%0d]: got cycle=%0d result=%h want %0d %h", i, dcyc[i], dres[i], 2 + 3 * i, want);
                end
            end
        end
        total++;
        if (overlap !== 0) begin
            bad++;
            $display("FAIL b2b_overlap: got %0d want 0", overlap);
        end
        model_acc = 8'h06;
    endtask

    task automatic test_reset_mid_mul;
        int g0, g1, d1, done0_seen;
        logic [7:0] r;

        g0 = -1; g1 = -1; d1 = -1; done0_seen = 0; r = '0;
        req0 = 1'b1; op0 = 3'd7; a0 = 4'd7; b0 = 4'd5;
        for (int cyc = 1; cyc <= 5 && g0 < 0; cyc++) begin
            @(posedge clock);
            #1;
            if (gnt0) g0 = cyc;
        end
        req0 = 1'b0;
        req1 = 1'b1; op1 = 3'd0; a1 = 4'd2; b1 = 4'd3;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (g0 !== 1) begin
            bad++;
            $display("FAIL rst_mul_gnt: got %0d want 1", g0);
        end
        total++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b0 || alu_reg !== 8'h00 || result !== 8'h00) begin
            bad++;
            $display("FAIL rst_mul_state: got ctrl=%b acc=%h result=%h want 00000 00 00",
                     {gnt0, gnt1, done0, done1, busy}, alu_reg, result);
        end
        reset = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clock);
            #1;
            if (done0) done0_seen++;
            if (gnt1 && g1 < 0) begin
                g1 = cyc;
                req1 = 1'b0;
            end
            if (done1 && d1 < 0) begin
                d1 = cyc;
                r  = result;
            end
        end
        total++;
        if (g1 !== 1 || d1 !== 2 || r !== 8'h05) begin
            bad++;
            $display("FAIL rst_pending_req1: got gnt=%0d done=%0d result=%h want 1 2 05", g1, d1, r);
        end
        total++;
        if (done0_seen !== 0) begin
            bad++;
            $display("FAIL rst_no_done0: got %0d want 0", done0_seen);
        end
        model_acc = 8'h05;
    endtask

    task automatic test_ignored_pulse;
        int g0, d0, stray;
        logic [7:0] r;

        g0 = -1; d0 = -1; stray = 0; r = '0;
        req0 = 1'b1; op0 = 3'd7; a0 = 4'd6; b0 = 4'd9;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clock);
            #1;
            if (gnt0 && g0 < 0) begin
                g0 = cyc;
                req0 = 1'b0; a0 = 4'd0; b0 = 4'd0;
            end
            if (cyc == 2) begin
                req1 = 1'b1; op1 = 3'd0; a1 = 4'd1; b1 = 4'd1;
            end
            if (cyc == 3) req1 = 1'b0;
            if (gnt1 || done1) stray++;
            if (done0 && d0 < 0) begin
                d0 = cyc;
                r  = result;
            end
        end
        total++;
        if (g0 !== 1 || d0 !== 5 || r !== 8'h36) begin
            bad++;
            $display("FAIL pulse_owner: got gnt=%0d done=%0d result=%h want 1 5 36", g0, d0, r);
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL pulse_ignored: got %0d stray gnt1/done1 want 0", stray);
        end
        model_acc = 8'h36;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        model_acc = '0;

        test_reset;
        test_alu_ops;
        test_multiply;
        test_random;
        test_back_to_back;
        test_reset_mid_mul;
        test_ignored_pulse;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
